// File: rtl/fifo_packet_writer.sv
// rtl/fifo_packet_writer.sv - write-side packet producer for the dual-clock word buffer
//
// Purpose:
//    Turns one start command (base, length) into a framed packet of 16-bit
//    words pushed into the buffer write port: header {8'hA5, length[7:0]},
//    payload base+i for i = 0..length-1, then the 16-bit modulo sum of the
//    payload as a trailer. Writes stall while buffer_full is high.
//
// Ports:
//    clock        in   write-domain clock
//    reset        in   synchronous, active-high reset
//    start        in   command strobe, accepted only in IDLE
//    base         in   first payload word, latched on an accepted start
//    length       in   payload word count, latched on an accepted start
//    buffer_full  in   buffer full flag; blocks the write enable
//    data_1_en    out  buffer write enable (combinational on buffer_full)
//    data_1       out  word offered to the buffer
//    busy         out  packet in flight (HEADER, PAYLOAD, TRAILER)
//    done         out  one-cycle pulse after the trailer is accepted
//    words_sent   out  words accepted for the current or last packet

module fifo_packet_writer #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [15:0]          base,
   input  logic [LEN_WIDTH-1:0] length,
   input  logic                 buffer_full,
   output logic                 data_1_en,
   output logic [15:0]          data_1,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_WIDTH:0]   words_sent
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HEADER  = 3'd1;
   localparam logic [2:0] PAYLOAD = 3'd2;
   localparam logic [2:0] TRAILER = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH:0]   SENT_ONE = (LEN_WIDTH + 1)'(1);

   logic [2:0]           state;
   logic [15:0]          base_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] count;
   logic [15:0]          checksum;
   logic [15:0]          checksum_next;
   logic [15:0]          data_q;
   logic [7:0]           len8;
   logic                 accept;

   // Header carries the length zero-extended or truncated to 8 bits.
   generate
      if (LEN_WIDTH >= 8) begin : g_len_trunc
         assign len8 = length[7:0];
      end else begin : g_len_ext
         assign len8 = {{(8 - LEN_WIDTH){1'b0}}, length};
      end
   endgenerate

   assign busy      = (state == HEADER) || (state == PAYLOAD) || (state == TRAILER);
   assign done      = (state == DONE);
   assign data_1_en = busy && !buffer_full;
   assign accept    = data_1_en;
   assign data_1    = data_q;

   // data_q already holds the payload word being accepted, so the running
   // sum can absorb it directly; on the last payload word this sum is the
   // trailer.
   assign checksum_next = checksum + data_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         count      <= '0;
         checksum   <= '0;
         data_q     <= '0;
         words_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_q     <= base;
                  len_q      <= length;
                  count      <= '0;
                  checksum   <= '0;
                  words_sent <= '0;
                  data_q     <= {8'hA5, len8};
                  state      <= HEADER;
               end
            end

            HEADER: begin
               if (accept) begin
                  words_sent <= words_sent + SENT_ONE;
                  if (len_q == '0) begin
                     data_q <= 16'h0000;
                     state  <= TRAILER;
                  end else begin
                     data_q <= base_q;
                     state  <= PAYLOAD;
                  end
               end
            end

            PAYLOAD: begin
               if (accept) begin
                  words_sent <= words_sent + SENT_ONE;
                  checksum   <= checksum_next;
                  if (count == len_q - LEN_ONE) begin
                     data_q <= checksum_next;
                     state  <= TRAILER;
                  end else begin
                     data_q <= data_q + 16'h0001;
                     count  <= count + LEN_ONE;
                  end
               end
            end

            TRAILER: begin
               if (accept) begin
                  words_sent <= words_sent + SENT_ONE;
                  state      <= DONE;
               end
            end

            DONE: begin
               // data_1 keeps the trailer during DONE and returns to zero in IDLE.
               data_q <= 16'h0000;
               state  <= IDLE;
            end

            default: begin
               data_q <= 16'h0000;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packet_writer.sv
// tb/tb_fifo_packet_writer.sv - self-checking bench for fifo_packet_writer

module tb_fifo_packet_writer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] base;
   logic [7:0]  length;
   logic        buffer_full;
   logic        data_1_en;
   logic [15:0] data_1;
   logic        busy;
   logic        done;
   logic [8:0]  words_sent;

   int checks;
   int errors;

   fifo_packet_writer #(.LEN_WIDTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .base        (base),
      .length      (length),
      .buffer_full (buffer_full),
      .data_1_en   (data_1_en),
      .data_1      (data_1),
      .busy        (busy),
      .done        (done),
      .words_sent  (words_sent)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] base;
      logic [7:0]  length;
      int          stall_idx;   // accepted-word index at which buffer_full rises, -1 for none
      int          stall_n;     // cycles of buffer_full
      int          poke_en;     // edge index at which a stray start is driven, -1 for none
      int          exp_n;       // expected accepted words
      logic [15:0] exp_w [6];
      int          exp_done;    // edge after the start edge that is followed by done
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_packet(input int vi);
      int  k;
      int  en;
      int  stall_left;
      bit  got_done;
      k          = 0;
      en         = 0;
      stall_left = vecs[vi].stall_n;
      got_done   = 0;
      base        = vecs[vi].base;
      length      = vecs[vi].length;
      buffer_full = 1'b0;
      start       = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      while (!got_done && en < 200) begin
         buffer_full = (vecs[vi].stall_idx == k) && (stall_left > 0);
         if (buffer_full) stall_left--;
         if (vecs[vi].poke_en == en) begin
            start  = 1'b1;
            base   = 16'h5555;
            length = 8'd7;
         end else begin
            start = 1'b0;
         end
         #1;
         if (done) begin
            got_done = 1;
            chk("done_edge", en, vecs[vi].exp_done);
            chk("done_busy", busy, 1'b0);
            chk("done_en", data_1_en, 1'b0);
            chk("done_words_sent", words_sent, vecs[vi].exp_n);
            chk("done_trailer_hold", data_1, vecs[vi].exp_w[vecs[vi].exp_n - 1]);
         end else begin
            chk("busy", busy, 1'b1);
            chk("en_follows_full", data_1_en, !buffer_full);
            if (k < vecs[vi].exp_n) chk("word", data_1, vecs[vi].exp_w[k]);
            else chk("extra_word", k, vecs[vi].exp_n);
            if (data_1_en) k++;
            @(posedge clock); #1;
            en++;
         end
      end
      if (!got_done) chk("done_timeout", 0, 1);
      chk("word_count", k, vecs[vi].exp_n);
      // A start held in the DONE cycle must be ignored.
      start       = (vecs[vi].poke_en >= 0);
      buffer_full = 1'b0;
      @(posedge clock); #1;
      start = 1'b0;
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_data", data_1, 16'h0000);
      chk("idle_words_hold", words_sent, vecs[vi].exp_n);
      @(posedge clock); #1;
      chk("no_second_packet", busy, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0] = '{16'h0010, 8'd3, -1, 0, -1, 5,
                  '{16'hA503, 16'h0010, 16'h0011, 16'h0012, 16'h0033, 16'h0000}, 5};
      vecs[1] = '{16'h1234, 8'd0, -1, 0, -1, 2,
                  '{16'hA500, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2};
      vecs[2] = '{16'hFFFE, 8'd3, -1, 0, -1, 5,
                  '{16'hA503, 16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFD, 16'h0000}, 5};
      vecs[3] = '{16'h0100, 8'd4, 2, 4, -1, 6,
                  '{16'hA504, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0406}, 10};
      vecs[4] = '{16'h0010, 8'd3, -1, 0, 2, 5,
                  '{16'hA503, 16'h0010, 16'h0011, 16'h0012, 16'h0033, 16'h0000}, 5};
      vecs[5] = '{16'h1234, 8'd1, -1, 0, -1, 3,
                  '{16'hA501, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000}, 3};

      reset       = 1'b1;
      start       = 1'b0;
      base        = 16'h0000;
      length      = 8'd0;
      buffer_full = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_en", data_1_en, 1'b0);
      chk("rst_data", data_1, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_words", words_sent, 9'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 6; i++) run_packet(i);

      // Reset after two payload words: header E1, payload E2/E3.
      base   = 16'h0020;
      length = 8'd5;
      start  = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("mid_words", words_sent, 9'd3);
      chk("mid_data", data_1, 16'h0022);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("mid_rst_en", data_1_en, 1'b0);
      chk("mid_rst_data", data_1, 16'h0000);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_words", words_sent, 9'd0);
      run_packet(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
